// File: rtl/spi_fsm_controller_pkg.sv
// Shared definitions for the SPI memory-slave transaction sequencer:
// state encoding, default frame width and the meaning of the R/W bit.
package spi_fsm_controller_pkg;

    localparam int   DEF_WIDTH = 8;
    localparam logic RW_READ   = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_GET_ADDR    = 3'd1,
        ST_DECODE      = 3'd2,
        ST_READ_LOAD   = 3'd3,
        ST_READ_SHIFT  = 3'd4,
        ST_WRITE_GET   = 3'd5,
        ST_WRITE_STORE = 3'd6,
        ST_DONE        = 3'd7
    } state_t;

endpackage

// File: rtl/spi_fsm_controller_bit_counter.sv
// Bit counter for one SPI frame: synchronous clear, gated increment that
// saturates at WIDTH, and a flag marking that the next increment completes
// the frame.
module spi_bit_counter #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_last
);

    logic [CNT_W-1:0] r_cnt;

    // Count register: clear wins over increment; stop at WIDTH so it never wraps.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != CNT_W'(WIDTH))) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Terminal flag: the edge being counted now is the WIDTH-th of the frame.
    always_comb begin
        o_cnt  = r_cnt;
        o_last = (r_cnt == CNT_W'(WIDTH - 1));
    end

endmodule

// File: rtl/spi_fsm_controller.sv
// Transaction sequencer for the SPI memory slave. Collects the address+R/W
// byte, then either captures a write byte into memory or loads the shift
// register and drives MISO for a read byte. All outputs are decoded from
// registered state. Raising cs_n in any active state returns to IDLE.
module spi_fsm_controller
    import spi_fsm_controller_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cs_n,
    input  logic             sclk_pos,
    input  logic             sclk_neg,
    input  logic             rw_bit,
    output logic             addr_we,
    output logic             sr_load,
    output logic             dm_we,
    output logic             miso_en,
    output logic             busy,
    output logic [CNT_W-1:0] bit_cnt
);

    state_t           r_state;
    state_t           w_next;
    logic             r_rd;
    logic             w_clr;
    logic             w_inc;
    logic             w_last;
    logic [CNT_W-1:0] w_cnt;

    spi_bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
        .i_clk   (clk),
        .i_reset (reset),
        .i_clr   (w_clr),
        .i_inc   (w_inc),
        .o_cnt   (w_cnt),
        .o_last  (w_last)
    );

    // State register; async reset aborts any transaction immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Remembers the direction decoded for this transaction so MISO stays
    // driven through DONE after a read until chip select is released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            r_rd <= 1'b0;
        end else if (r_state == ST_DECODE) begin
            r_rd <= (rw_bit == RW_READ);
        end
    end

    // Next-state and counter control. cs_n high outranks every other
    // transition, and also suppresses counting on that cycle.
    always_comb begin
        w_next = r_state;
        w_clr  = 1'b0;
        w_inc  = 1'b0;
        if ((r_state != ST_IDLE) && cs_n) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!cs_n) begin
                        w_next = ST_GET_ADDR;
                        w_clr  = 1'b1;
                    end
                end
                ST_GET_ADDR: begin
                    if (sclk_pos) begin
                        w_inc = 1'b1;
                        if (w_last) w_next = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    w_clr  = 1'b1;
                    w_next = (rw_bit == RW_READ) ? ST_READ_LOAD : ST_WRITE_GET;
                end
                ST_READ_LOAD: begin
                    w_next = ST_READ_SHIFT;
                end
                ST_READ_SHIFT: begin
                    if (sclk_neg) begin
                        w_inc = 1'b1;
                        if (w_last) w_next = ST_DONE;
                    end
                end
                ST_WRITE_GET: begin
                    if (sclk_pos) begin
                        w_inc = 1'b1;
                        if (w_last) w_next = ST_WRITE_STORE;
                    end
                end
                ST_WRITE_STORE: begin
                    w_next = ST_DONE;
                end
                ST_DONE: begin
                    w_next = ST_DONE;
                end
                default: begin
                    w_next = ST_IDLE;
                end
            endcase
        end
    end

    // Moore output decode from the registered state.
    always_comb begin
        addr_we = (r_state == ST_DECODE);
        sr_load = (r_state == ST_READ_LOAD);
        dm_we   = (r_state == ST_WRITE_STORE);
        miso_en = (r_state == ST_READ_LOAD) || (r_state == ST_READ_SHIFT) ||
                  ((r_state == ST_DONE) && r_rd);
        busy    = (r_state != ST_IDLE);
        bit_cnt = w_cnt;
    end

endmodule

// File: tb/tb_spi_fsm_controller.sv
// Bench for spi_fsm_controller. Stimulus drives whole transactions; the
// expected strobe events of each transaction are pushed into exp_q before
// it starts, and an independent monitor pops and compares every strobe the
// DUT emits.
module tb_spi_fsm_controller;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cs_n = 1'b1;
    logic       sclk_pos = 1'b0;
    logic       sclk_neg = 1'b0;
    logic       rw_bit = 1'b0;
    logic       addr_we;
    logic       sr_load;
    logic       dm_we;
    logic       miso_en;
    logic       busy;
    logic [3:0] bit_cnt;

    logic [7:0] sr = 8'h00;
    logic [W-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    spi_fsm_controller #(.WIDTH(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .cs_n     (cs_n),
        .sclk_pos (sclk_pos),
        .sclk_neg (sclk_neg),
        .rw_bit   (rw_bit),
        .addr_we  (addr_we),
        .sr_load  (sr_load),
        .dm_we    (dm_we),
        .miso_en  (miso_en),
        .busy     (busy),
        .bit_cnt  (bit_cnt)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- common check ----------------
    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Event word: {addr_we, sr_load, dm_we, miso_en, bit_cnt}
    function automatic logic [W-1:0] ev(input logic a, input logic s, input logic d,
                                        input logic m, input logic [3:0] c);
        return {a, s, d, m, c};
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!reset && (addr_we || sr_load || dm_we)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", int'({addr_we, sr_load, dm_we, miso_en, bit_cnt}), 0);
            end else begin
                check("strobe_event", int'({addr_we, sr_load, dm_we, miso_en, bit_cnt}),
                      int'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pos_strobe(input logic b);
        sr       = {sr[6:0], b};
        rw_bit   = sr[0];
        sclk_pos = 1'b1;
        tick();
        sclk_pos = 1'b0;
        repeat (3) tick();
    endtask

    task automatic neg_strobe();
        sclk_neg = 1'b1;
        tick();
        sclk_neg = 1'b0;
        repeat (3) tick();
    endtask

    // Address byte, MSB first; checks strobe latency around the 8th edge.
    task automatic send_addr(input logic [7:0] a);
        for (int i = 7; i >= 0; i--) begin
            sr       = {sr[6:0], a[i]};
            rw_bit   = sr[0];
            sclk_pos = 1'b1;
            tick();
            sclk_pos = 1'b0;
            if (i == 0) check("addr_we_latency", int'(addr_we), 1);
            tick();
            if (i == 0) check("sr_load_latency", int'(sr_load), int'(a[0]));
            repeat (2) tick();
        end
    endtask

    // Starts a transaction and leaves cs_n low. nbits = data edges applied.
    task automatic run_txn(input logic [7:0] a, input logic [7:0] d, input int nbits);
        exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 1'b0, 4'd8));
        if (a[0]) exp_q.push_back(ev(1'b0, 1'b1, 1'b0, 1'b1, 4'd0));
        else if (nbits == 8) exp_q.push_back(ev(1'b0, 1'b0, 1'b1, 1'b0, 4'd8));
        cs_n = 1'b0;
        tick();
        check("start_cnt", int'(bit_cnt), 0);
        check("start_busy", int'(busy), 1);
        send_addr(a);
        if (a[0]) begin
            for (int k = 0; k < nbits; k++) neg_strobe();
            check("read_miso_en", int'(miso_en), 1);
        end else begin
            for (int k = 0; k < nbits; k++) begin
                pos_strobe(d[7-k]);
            end
            check("write_miso_en", int'(miso_en), 0);
        end
        check("data_cnt", int'(bit_cnt), nbits);
    endtask

    task automatic end_txn();
        cs_n = 1'b1;
        tick();
        check("idle_busy", int'(busy), 0);
        check("idle_miso_en", int'(miso_en), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (2) tick();
        check("rst_busy", int'(busy), 0);
        check("rst_cnt", int'(bit_cnt), 0);
        check("rst_strobes", int'({addr_we, sr_load, dm_we, miso_en}), 0);
        reset = 1'b0;
        tick();

        // Write 0x54 / 0xC3, then extra SCLK edges in DONE.
        run_txn(8'h54, 8'hC3, 8);
        repeat (10) pos_strobe(1'b1);
        repeat (10) neg_strobe();
        check("done_cnt_hold", int'(bit_cnt), 8);
        check("done_busy", int'(busy), 1);
        end_txn();

        // Read 0x55; MISO stays enabled in DONE until cs_n rises.
        run_txn(8'h55, 8'h00, 8);
        tick();
        check("read_done_miso", int'(miso_en), 1);
        end_txn();

        // Abort a write after 5 data edges: no dm_we expected.
        run_txn(8'h2C, 8'hA5, 5);
        end_txn();
        cs_n = 1'b0;
        tick();
        check("post_abort_cnt", int'(bit_cnt), 0);
        cs_n = 1'b1;
        tick();

        // Async reset mid READ_SHIFT at bit_cnt=3.
        run_txn(8'h0F, 8'h00, 3);
        reset = 1'b1;
        #1;
        check("async_rst_miso", int'(miso_en), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_cnt", int'(bit_cnt), 0);
        cs_n = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        // Back-to-back write then read with 1 clk of cs_n high.
        run_txn(8'h10, 8'h3C, 8);
        cs_n = 1'b1;
        tick();
        run_txn(8'h11, 8'h00, 8);
        end_txn();

        // Randomized transactions, some aborted mid data byte.
        for (int t = 0; t < 12; t++) begin
            logic [7:0] a;
            logic [7:0] d;
            int nb;
            a  = 8'($urandom_range(0, 255));
            d  = 8'($urandom_range(0, 255));
            nb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 8;
            run_txn(a, d, nb);
            repeat ($urandom_range(0, 3)) tick();
            end_txn();
        end

        repeat (4) tick();
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
